// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side valid/ready word handshake for the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned BITS_N = 8
);
  logic [BITS_N-1:0] data_tx;
  logic              valid;
  logic              ready;

  modport master (output data_tx, output valid, input ready);
  modport slave  (input data_tx, input valid, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Words are queued in a FIFO and sent
// LSB-first with a start bit, optional parity and 1 or 2 stop bits. Frames go out
// back-to-back, with no idle gap, while words are queued.
// Optional feature macro: UART_TX_BREAK_EN adds the send_break input and a BREAK state
// that holds the line low for at least one frame time.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BITS_N       = 8,
  parameter int unsigned PARITY_TYPE  = 2,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               tx_if,
`ifdef UART_TX_BREAK_EN
  input  logic                        send_break,
`endif
  output logic                        uart_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(BITS_N) + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam bit          HAS_PARITY = (PARITY_TYPE != 0);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_N - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);
`ifdef UART_TX_BREAK_EN
  localparam int unsigned FRAME_CLKS =
    (1 + BITS_N + ((PARITY_TYPE != 0) ? 1 : 0) + STOP_BITS) * CLKS_PER_BIT;
  localparam int unsigned BRK_W = $clog2(FRAME_CLKS);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(FRAME_CLKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    , S_BREAK = 3'd5
`endif
  } state_t;

  state_t            state, state_nx, launch_c;
  logic [BITS_N-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [BITS_N-1:0] shift, shift_nx, head_c;
  logic              par_bit, par_nx;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_n;
  logic              stop_n;
  logic              push_c, pop_c, launch_pop_c, bit_end_c, line_nx, busy_nx;
`ifdef UART_TX_BREAK_EN
  logic [BRK_W-1:0]  brk_cnt;
`endif

  assign tx_if.ready = (fifo_count != FULL_CNT);
  assign push_c      = tx_if.valid && tx_if.ready;
  assign bit_end_c   = (clk_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state; launch_c is what follows IDLE or the last stop cycle (break beats a pop)
  always_comb begin
    state_nx     = state;
    pop_c        = 1'b0;
    launch_c     = S_IDLE;
    launch_pop_c = 1'b0;
    if (fifo_count != '0) begin
      launch_c     = S_START;
      launch_pop_c = 1'b1;
    end
`ifdef UART_TX_BREAK_EN
    if (send_break) begin
      launch_c     = S_BREAK;
      launch_pop_c = 1'b0;
    end
`endif
    case (state)
      S_IDLE: begin
        state_nx = launch_c;
        pop_c    = launch_pop_c;
      end
      S_START:  if (bit_end_c) state_nx = S_DATA;
      S_DATA:   if (bit_end_c && bit_n == BIT_LAST) state_nx = HAS_PARITY ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end_c) state_nx = S_STOP;
      S_STOP: begin
        if (bit_end_c && stop_n == STOP_LAST) begin
          state_nx = launch_c;
          pop_c    = launch_pop_c;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK:  if (brk_cnt == BRK_LAST && !send_break) state_nx = S_STOP;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output comb: line level and busy for the state being entered, plus shift/parity loads
  always_comb begin
    head_c   = mem[rd_ptr];
    shift_nx = shift;
    par_nx   = par_bit;
    line_nx  = 1'b1;
    if (pop_c) begin
      shift_nx = head_c;
      par_nx   = (PARITY_TYPE == 1) ? ~^head_c : ^head_c;
    end else if (state == S_DATA && bit_end_c) begin
      shift_nx = shift >> 1;
    end
    case (state_nx)
      S_START:  line_nx = 1'b0;
      S_DATA:   line_nx = shift_nx[0];
      S_PARITY: line_nx = par_nx;
`ifdef UART_TX_BREAK_EN
      S_BREAK:  line_nx = 1'b0;
`endif
      default:  line_nx = 1'b1;
    endcase
    busy_nx = (state_nx != S_IDLE);
  end

  // Registered line, busy and the latched word/parity of the frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_out <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      uart_out <= line_nx;
      busy     <= busy_nx;
      shift    <= shift_nx;
      par_bit  <= par_nx;
    end
  end

  // Bit timing; each counter restarts on entry to the state that uses it
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
      bit_n   <= '0;
      stop_n  <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_end_c || state_nx != state) clk_cnt <= '0;
      else                                                  clk_cnt <= clk_cnt + 1'b1;
      if (state != S_DATA) bit_n  <= '0;
      else if (bit_end_c)  bit_n  <= bit_n + 1'b1;
      if (state != S_STOP) stop_n <= 1'b0;
      else if (bit_end_c)  stop_n <= stop_n + 1'b1;
    end
  end

`ifdef UART_TX_BREAK_EN
  // Break duration, saturating once the minimum frame time has elapsed
  always_ff @(posedge clk) begin
    if (rst || state != S_BREAK) brk_cnt <= '0;
    else if (brk_cnt != BRK_LAST) brk_cnt <= brk_cnt + 1'b1;
  end
`endif

  // FIFO storage; contents need no reset, only the pointers do
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= tx_if.data_tx;
  end

  // FIFO pointers and occupancy (word on the line is not counted)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench. Accepted words are queued as expectations; a line
// monitor decodes frames from uart_out at mid-bit and checks them against the queue.
// A second instance (7 data bits, odd parity, 2 stop bits) is checked cycle by cycle.
module tb_uart_tx_fifo;
  localparam int unsigned CPB    = 5;
  localparam int unsigned BITS_N = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned NBITS  = 1 + BITS_N + 1 + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b1;
  logic [BITS_N-1:0] sb_q [$];

  uart_tx_fifo_if #(.BITS_N(BITS_N)) bus ();
  uart_tx_fifo_if #(.BITS_N(7))      bus2 ();
  logic                     uart_out, busy, uart_out2, busy2;
  logic [$clog2(DEPTH):0]   fifo_count, fifo_count2;
`ifdef UART_TX_BREAK_EN
  logic send_break, send_break2;
`endif

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(BITS_N), .PARITY_TYPE(2), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_if(bus),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .uart_out(uart_out), .busy(busy), .fifo_count(fifo_count));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .BITS_N(7), .PARITY_TYPE(1), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .tx_if(bus2),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break2),
`endif
    .uart_out(uart_out2), .busy(busy2), .fifo_count(fifo_count2));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference parity: count ones; even parity bit makes the total even, odd makes it odd
  function automatic int exp_parity(input int word, input int nbits, input int ptype);
    int ones = 0;
    for (int i = 0; i < nbits; i++) ones += (word >> i) & 1;
    if (ptype == 1) return (ones % 2 == 0) ? 1 : 0;
    return ones % 2;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.valid = 1'b0;
    bus2.valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one word; called at a negedge, returns at the negedge after acceptance
  task automatic push_word(input logic [BITS_N-1:0] d);
    int waited = 0;
    bus.data_tx = d;
    bus.valid   = 1'b1;
    while (!bus.ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", int'(bus.ready), 1);
    if (bus.ready) sb_q.push_back(d);
    @(negedge clk);
    bus.valid = 1'b0;
  endtask

  // Length of the next busy run, in cycles
  task automatic busy_run(output int n);
    int w = 0;
    while (!busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((sb_q.size() != 0 || busy) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    check(name, sb_q.size(), 0);
  endtask

  // Line monitor: first low sample is cycle 0 of the start bit; sample each bit mid-period
  initial begin : monitor
    logic              line_bits [NBITS];
    logic [BITS_N-1:0] word, exp_w;
    int                cyc;
    bit                aborted;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_out == 1'b0) begin
        cyc = 0;
        aborted = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
          while (cyc < b * CPB + CPB / 2) begin
            @(negedge clk);
            cyc++;
            if (rst || !mon_en) aborted = 1'b1;
          end
          line_bits[b] = uart_out;
        end
        if (!aborted) begin
          for (int i = 0; i < BITS_N; i++) word[i] = line_bits[1 + i];
          check("mon_start_bit", int'(line_bits[0]), 0);
          check("mon_stop_bit", int'(line_bits[NBITS-1]), 1);
          check("mon_expected_pending", int'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            exp_w = sb_q.pop_front();
            check("mon_word", int'(word), int'(exp_w));
            check("mon_parity", int'(line_bits[NBITS-2]), exp_parity(int'(exp_w), BITS_N, 2));
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n, accepted, acc2, lows, gap, bad;
    logic [BITS_N-1:0] val;
    logic [6:0]        w2 [2];
    int                exp_bits [$];

`ifdef UART_TX_BREAK_EN
    send_break  = 1'b0;
    send_break2 = 1'b0;
`endif
    bus.data_tx  = '0;
    bus2.data_tx = '0;
    rst = 1'b1;
    bus.valid = 1'b0;
    bus2.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_out", int'(uart_out), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_ready", int'(bus.ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Single word: start bit one edge after the push, 55-cycle frame
    push_word(8'hA5);
    check("lat_e0_line", int'(uart_out), 1);
    check("lat_e0_count", int'(fifo_count), 1);
    check("lat_e0_busy", int'(busy), 0);
    @(negedge clk);
    check("lat_e1_line", int'(uart_out), 0);
    check("lat_e1_busy", int'(busy), 1);
    check("lat_e1_count", int'(fifo_count), 0);
    busy_run(n);
    check("frame_len_a5", n, 55);
    check("a5_count_after", int'(fifo_count), 0);

    // Two words on consecutive cycles: no idle gap between frames
    push_word(8'h00);
    push_word(8'hFF);
    busy_run(n);
    check("b2b_busy_len", n, 110);
    wait_drain("drain_b2b");

    // Continuous valid from reset: fills FIFO plus the shift register
    do_reset();
    @(negedge clk);
    accepted = 0;
    val = 8'h10;
    bus.valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      bus.data_tx = val;
      if (bus.ready) begin
        sb_q.push_back(val);
        accepted++;
      end
      val++;
      @(negedge clk);
    end
    check("fill_accepted", accepted, 17);
    check("fill_count", int'(fifo_count), 16);
    check("fill_ready", int'(bus.ready), 0);
    acc2 = 0;
    for (int k = 30; k < 140; k++) begin
      bus.data_tx = val;
      if (bus.ready) begin
        sb_q.push_back(val);
        acc2++;
      end
      val++;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    check("refill_accepts", acc2, 2);
    wait_drain("drain_fill");

    // Random words with random gaps
    for (int i = 0; i < 40; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      push_word(BITS_N'($urandom));
    end
    wait_drain("drain_random");

    // Reset during data bit 3 with 4 words queued
    for (int i = 0; i < 5; i++) push_word(BITS_N'($urandom));
    repeat (18) @(negedge clk);
    check("pre_reset_count", int'(fifo_count), 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uart_out", int'(uart_out), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_ready", int'(bus.ready), 1);
    rst = 1'b0;
    sb_q.delete();
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_out == 1'b0) lows++;
    end
    check("post_rst_line_lows", lows, 0);

    // 7 data bits, odd parity, 2 stop bits: two frames compared cycle by cycle
    w2[0] = 7'h41;
    w2[1] = 7'($urandom);
    for (int f = 0; f < 2; f++) begin
      exp_bits.push_back(0);
      for (int i = 0; i < 7; i++) exp_bits.push_back((int'(w2[f]) >> i) & 1);
      exp_bits.push_back(exp_parity(int'(w2[f]), 7, 1));
      exp_bits.push_back(1);
      exp_bits.push_back(1);
    end
    bus2.valid = 1'b1;
    bus2.data_tx = w2[0];
    @(negedge clk);
    bus2.data_tx = w2[1];
    @(negedge clk);
    bus2.valid = 1'b0;
    for (int b = 0; b < exp_bits.size(); b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (int'(uart_out2) != exp_bits[b]) bad++;
        @(negedge clk);
      end
      check($sformatf("d2_bit%0d", b), bad, 0);
    end
    check("d2_busy_after", int'(busy2), 0);
    check("d2_line_after", int'(uart_out2), 1);

`ifdef UART_TX_BREAK_EN
    // Break held 20 cycles while idle, word pushed during the break
    mon_en = 1'b0;
    @(negedge clk);
    fork
      begin
        send_break = 1'b1;
        for (int i = 0; i < 20; i++) begin
          if (i == 10) begin
            bus.data_tx = 8'h55;
            bus.valid   = 1'b1;
            check("brk_push_ready", int'(bus.ready), 1);
            sb_q.push_back(8'h55);
          end
          if (i == 11) bus.valid = 1'b0;
          @(negedge clk);
        end
        send_break = 1'b0;
      end
      begin
        int w = 0, lo = 0, hi = 0;
        while (uart_out && w < 100) begin
          @(negedge clk);
          w++;
        end
        while (!uart_out && lo < 1000) begin
          lo++;
          @(negedge clk);
        end
        mon_en = 1'b1;
        while (uart_out && hi < 1000) begin
          hi++;
          @(negedge clk);
        end
        check("brk_low_len", lo, 55);
        check("brk_high_len", hi, 5);
      end
    join
    wait_drain("drain_break");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter, next generation of the team's single-frame TX serializer. Accepts words over a valid/ready handshake into an internal FIFO and serializes them LSB-first with start, optional parity and 1 or 2 stop bits. Sends back-to-back frames with no idle gap while the FIFO holds data. Sits between the motor/telemetry logic and the FPGA TX pin, so producers can burst words without waiting on the line.

Parameters:
CLKS_PER_BIT, 434, clocks per bit period (50 MHz / 115200); legal range >= 2; benches use 5.
BITS_N, 8, data bits per frame; legal range 5..9.
PARITY_TYPE, 2, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 16, FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
data_tx  in  BITS_N  word to enqueue.
valid  in  1  data_tx valid.
ready  out  1  FIFO can accept; equals !full.
uart_out  out  1  serial line; idle high.
busy  out  1  serializer not IDLE.
fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently queued, not counting the word on the line.

Behaviour:
- Reset: clk and rst are as stated above (rst synchronous, active-high; clock clk). On reset, FIFO is flushed, fifo_count=0, ready=1, uart_out=1, busy=0, state=IDLE, and bit/clock counters are cleared.
- Reset mid-frame aborts the frame. uart_out is 1 from the first cycle after the rst edge. No partial frame resumes.
- Push: occurs on a clock edge where valid && ready. It writes at the write pointer, and the pointer wraps modulo FIFO_DEPTH. When full, valid is ignored and data is not stored.
- Pop: occurs when the serializer leaves IDLE, or ends STOP, with fifo_count != 0. The head word is loaded into the shift register and the read pointer advances (wraps).
- Simultaneous push and pop: fifo_count is unchanged.
- fifo_count, ready: registered count; ready is combinational from the count.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: uart_out=1. If fifo_count != 0, pop and go to START next edge.
- START: uart_out=0 for CLKS_PER_BIT cycles.
- DATA: sends shift[bit_n], bit_n = 0..BITS_N-1, each for CLKS_PER_BIT cycles.
- PARITY: only entered when PARITY_TYPE != 0.
  - Even parity: ^word.
  - Odd parity: ~^word.
  - Parity is computed on the latched word, never on data_tx.
- STOP: uart_out=1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle: if fifo_count != 0, pop and go directly to START (zero idle cycles); else go to IDLE.
- Latency: word pushed at edge E0 into an empty FIFO with the serializer IDLE. The start bit begins at E1, i.e. uart_out=0 after E1.
- Frame length: (1 + BITS_N + (PARITY_TYPE != 0) + STOP_BITS) * CLKS_PER_BIT cycles, exact.
- Counters:
  - Bit-period counter: 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - bit_n width: $clog2(BITS_N)+1.
  - Stop counter: counts STOP_BITS periods.
- Effective buffering is FIFO_DEPTH queued words plus 1 word in the shift register.
- busy = (state != IDLE).

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input port send_break (1 bit) and state BREAK.
  - In IDLE, or at the end of STOP, send_break=1 takes priority over FIFO pop and enters BREAK.
  - BREAK drives uart_out=0 while send_break=1, for a minimum of one full frame length.
  - BREAK then drives one STOP period high and returns to IDLE/START per normal STOP rules.
  - FIFO keeps accepting pushes during BREAK. busy=1 during BREAK.
- Undefined: no send_break port, no BREAK state; behaviour exactly as above.

Test Plan:
Benches use CLKS_PER_BIT=5, FIFO_DEPTH=16 unless noted.
1. Default parity, push 0xA5 once -> uart_out low 5 cycles starting one edge after the push; then bits 1,0,1,0,0,1,0,1 at 5 cycles each; parity 0; stop high 5; total 55 cycles; busy falls after stop; fifo_count returns 0.
2. Push 0x00 then 0xFF on consecutive cycles -> frame 2 start bit immediately follows frame 1 stop bit (0 idle cycles); parity bits 0 and 0; 110 cycles total high-to-idle.
3. Hold valid=1 with incrementing data from reset -> 17 words accepted; fifo_count reaches 16; ready=0. After frame 1 ends, the next pop sets ready=1 for one accept. Output order equals push order across pointer wrap.
4. rst asserted during data bit 3 of a frame, with 4 words queued -> next cycle: uart_out=1, busy=0, fifo_count=0, ready=1. Line stays high for 200 cycles.
5. BITS_N=7, PARITY_TYPE=1, STOP_BITS=2, push 0x41 -> data 1,0,0,0,0,0,1; parity 1; stop high 10 cycles; frame 55 cycles.
6. UART_TX_BREAK_EN, send_break held for 20 cycles while idle, with 0x55 pushed during break -> uart_out low 55 cycles (minimum frame), then high 5, then frame 0x55 starts.
